// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared main-memory port between icache fills and the dcache.
// Tracks outstanding load tags in an owner table and routes tagged responses back to the requester.
module mem_port_arbiter #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  input  logic              ic_squash,
  output logic              ic_resp_valid,
  output logic [ADDR_W-1:0] ic_resp_addr,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_store,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [ADDR_W-1:0] dc_resp_addr,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [TAG_W-1:0]  mem_accept_tag,
  input  logic [TAG_W-1:0]  mem_resp_tag,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int unsigned ENTRIES = 2 ** TAG_W;
  localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10
  } cmd_e;

  typedef enum logic {
    OWN_DC = 1'b0,
    OWN_IC = 1'b1
  } owner_e;

  logic              tbl_valid    [ENTRIES];
  owner_e            tbl_owner    [ENTRIES];
  logic              tbl_squashed [ENTRIES];
  logic [ADDR_W-1:0] tbl_addr     [ENTRIES];

  logic [CNT_W-1:0]  starve_cnt;
  logic              ic_eligible;
  logic              force_ic;
  logic              grant_ic;
  logic              grant_dc;
  logic              accepted;
  logic              alloc;
  owner_e            alloc_owner;
  logic [ADDR_W-1:0] alloc_addr;
  logic              resp_hit;
  cmd_e              cmd;

  always_comb begin
    ic_eligible  = ic_req_valid && !ic_squash;
    force_ic     = (starve_cnt == LIMIT) && ic_eligible;
    grant_ic     = !reset && ic_eligible && (force_ic || !dc_req_valid);
    grant_dc     = !reset && dc_req_valid && !force_ic;
    accepted     = mem_accept_tag != '0;
    ic_req_ready = grant_ic && accepted;
    dc_req_ready = grant_dc && accepted;

    cmd       = CMD_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_dc) begin
      cmd       = dc_req_store ? CMD_STORE : CMD_LOAD;
      mem_addr  = dc_req_addr;
      mem_wdata = dc_req_data;
    end else if (grant_ic) begin
      cmd      = CMD_LOAD;
      mem_addr = ic_req_addr;
    end
    mem_cmd = cmd;

    alloc       = ic_req_ready || (dc_req_ready && !dc_req_store);
    alloc_owner = ic_req_ready ? OWN_IC : OWN_DC;
    alloc_addr  = ic_req_ready ? ic_req_addr : dc_req_addr;
    resp_hit    = (mem_resp_tag != '0) && tbl_valid[mem_resp_tag];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_valid[TAG_W'(i)]    <= 1'b0;
        tbl_owner[TAG_W'(i)]    <= OWN_DC;
        tbl_squashed[TAG_W'(i)] <= 1'b0;
        tbl_addr[TAG_W'(i)]     <= '0;
      end
      starve_cnt    <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_addr  <= '0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_addr  <= '0;
      dc_resp_data  <= '0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;

      if (!ic_req_valid || ic_req_ready)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (ic_squash) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          if (tbl_valid[TAG_W'(i)] && tbl_owner[TAG_W'(i)] == OWN_IC)
            tbl_squashed[TAG_W'(i)] <= 1'b1;
        end
      end

      // A same-cycle squash also kills an icache response arriving now.
      if (resp_hit) begin
        tbl_valid[mem_resp_tag] <= 1'b0;
        if (tbl_owner[mem_resp_tag] == OWN_DC) begin
          dc_resp_valid <= 1'b1;
          dc_resp_addr  <= tbl_addr[mem_resp_tag];
          dc_resp_data  <= mem_resp_data;
        end else if (!tbl_squashed[mem_resp_tag] && !ic_squash) begin
          ic_resp_valid <= 1'b1;
          ic_resp_addr  <= tbl_addr[mem_resp_tag];
          ic_resp_data  <= mem_resp_data;
        end
      end

      // Allocation is written last so it overrides a same-tag free.
      if (alloc) begin
        assert (!tbl_valid[mem_accept_tag] || (mem_resp_tag == mem_accept_tag));
        tbl_valid[mem_accept_tag]    <= 1'b1;
        tbl_owner[mem_accept_tag]    <= alloc_owner;
        tbl_squashed[mem_accept_tag] <= 1'b0;
        tbl_addr[mem_accept_tag]     <= alloc_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation override, tag routing, squash and reset.
module tb_mem_port_arbiter;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_squash;
  logic              ic_resp_valid;
  logic [ADDR_W-1:0] ic_resp_addr;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_store;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [ADDR_W-1:0] dc_resp_addr;
  logic [DATA_W-1:0] dc_resp_data;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [TAG_W-1:0]  mem_accept_tag;
  logic [TAG_W-1:0]  mem_resp_tag;
  logic [DATA_W-1:0] mem_resp_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_squash(ic_squash),
    .ic_resp_valid(ic_resp_valid), .ic_resp_addr(ic_resp_addr), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_store(dc_req_store), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_addr(dc_resp_addr), .dc_resp_data(dc_resp_data),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_accept_tag(mem_accept_tag), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ic_req_valid = 0; ic_req_addr = '0; ic_squash = 0;
    dc_req_valid = 0; dc_req_store = 0; dc_req_addr = '0; dc_req_data = '0;
    mem_accept_tag = '0; mem_resp_tag = '0; mem_resp_data = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    dc_req_valid = 1; dc_req_addr = 32'h50; mem_accept_tag = 4'd1;
    #1;
    check("rst_cmd", 64'(mem_cmd), 64'd0);
    check("rst_dc_ready", 64'(dc_req_ready), 64'd0);
    tick(); tick();
    check("rst_dc_resp_valid", 64'(dc_resp_valid), 64'd0);
    check("rst_ic_resp_valid", 64'(ic_resp_valid), 64'd0);
    check("rst_dc_resp_addr", 64'(dc_resp_addr), 64'd0);
    check("rst_ic_resp_data", ic_resp_data, 64'd0);
    idle();
    reset = 0;
    tick();

    // dcache and icache together: dcache wins, response routed back on tag 3
    dc_req_valid = 1; dc_req_addr = 32'h100;
    ic_req_valid = 1; ic_req_addr = 32'h200;
    mem_accept_tag = 4'd3;
    #1;
    check("both_dc_ready", 64'(dc_req_ready), 64'd1);
    check("both_ic_ready", 64'(ic_req_ready), 64'd0);
    check("both_cmd", 64'(mem_cmd), 64'd1);
    check("both_addr", 64'(mem_addr), 64'h100);
    tick();
    idle();
    mem_resp_tag = 4'd3; mem_resp_data = 64'hD1D1_0000_0000_0003;
    tick();
    check("t3_dc_valid", 64'(dc_resp_valid), 64'd1);
    check("t3_dc_addr", 64'(dc_resp_addr), 64'h100);
    check("t3_dc_data", dc_resp_data, 64'hD1D1_0000_0000_0003);
    check("t3_ic_valid", 64'(ic_resp_valid), 64'd0);
    idle();
    tick();
    check("t3_dc_pulse", 64'(dc_resp_valid), 64'd0);

    // starvation: 8 dcache wins, then the icache is forced through
    dc_req_valid = 1; dc_req_store = 1; dc_req_addr = 32'h300; dc_req_data = 64'h33;
    ic_req_valid = 1; ic_req_addr = 32'h400;
    mem_accept_tag = 4'd1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("starve_dc_%0d", i), 64'(dc_req_ready), 64'd1);
      tick();
    end
    mem_accept_tag = 4'd7;
    #1;
    check("starve_ic_ready", 64'(ic_req_ready), 64'd1);
    check("starve_dc_ready", 64'(dc_req_ready), 64'd0);
    check("starve_cmd", 64'(mem_cmd), 64'd1);
    check("starve_addr", 64'(mem_addr), 64'h400);
    tick();
    mem_accept_tag = 4'd1;
    #1;
    check("starve_cleared_dc", 64'(dc_req_ready), 64'd1);
    check("starve_cleared_ic", 64'(ic_req_ready), 64'd0);
    tick();
    idle();
    mem_resp_tag = 4'd7; mem_resp_data = 64'h7777;
    tick();
    check("t7_ic_valid", 64'(ic_resp_valid), 64'd1);
    check("t7_ic_addr", 64'(ic_resp_addr), 64'h400);
    check("t7_ic_data", ic_resp_data, 64'h7777);
    idle();

    // squash pulse kills an outstanding icache load; request in squash cycle not issued
    ic_req_valid = 1; ic_req_addr = 32'h500; mem_accept_tag = 4'd5;
    #1;
    check("ic5_ready", 64'(ic_req_ready), 64'd1);
    tick();
    ic_squash = 1; ic_req_addr = 32'h510; mem_accept_tag = 4'd9;
    #1;
    check("squash_ic_ready", 64'(ic_req_ready), 64'd0);
    check("squash_cmd", 64'(mem_cmd), 64'd0);
    tick();
    idle();
    mem_resp_tag = 4'd5; mem_resp_data = 64'h5555;
    tick();
    check("squashed5_ic_valid", 64'(ic_resp_valid), 64'd0);
    idle();

    // squash in the same cycle as the icache response; dcache entry unaffected
    ic_req_valid = 1; ic_req_addr = 32'h600; mem_accept_tag = 4'd5;
    tick();
    idle();
    dc_req_valid = 1; dc_req_addr = 32'h700; mem_accept_tag = 4'd6;
    tick();
    idle();
    ic_squash = 1; mem_resp_tag = 4'd5; mem_resp_data = 64'h6565;
    tick();
    check("samecyc_ic_valid", 64'(ic_resp_valid), 64'd0);
    idle();
    mem_resp_tag = 4'd6; mem_resp_data = 64'h6666;
    tick();
    check("dc6_valid", 64'(dc_resp_valid), 64'd1);
    check("dc6_addr", 64'(dc_resp_addr), 64'h700);
    check("dc6_data", dc_resp_data, 64'h6666);
    idle();

    // dcache store: no table entry, no response
    dc_req_valid = 1; dc_req_store = 1; dc_req_addr = 32'h800;
    dc_req_data = 64'hCAFE_F00D_1234_5678; mem_accept_tag = 4'd2;
    #1;
    check("store_cmd", 64'(mem_cmd), 64'd2);
    check("store_wdata", mem_wdata, 64'hCAFE_F00D_1234_5678);
    check("store_ready", 64'(dc_req_ready), 64'd1);
    tick();
    idle();
    mem_resp_tag = 4'd2; mem_resp_data = 64'h2222;
    tick();
    check("store_dc_valid", 64'(dc_resp_valid), 64'd0);
    check("store_ic_valid", 64'(ic_resp_valid), 64'd0);
    idle();

    // same-tag free and allocate: old response delivered, new entry survives
    dc_req_valid = 1; dc_req_addr = 32'h900; mem_accept_tag = 4'd4;
    tick();
    idle();
    mem_resp_tag = 4'd4; mem_resp_data = 64'h4444;
    ic_req_valid = 1; ic_req_addr = 32'hA00; mem_accept_tag = 4'd4;
    tick();
    check("reuse_dc_valid", 64'(dc_resp_valid), 64'd1);
    check("reuse_dc_addr", 64'(dc_resp_addr), 64'h900);
    idle();
    mem_resp_tag = 4'd4; mem_resp_data = 64'hEEEE;
    tick();
    check("reuse_ic_valid", 64'(ic_resp_valid), 64'd1);
    check("reuse_ic_addr", 64'(ic_resp_addr), 64'hA00);
    check("reuse_ic_data", ic_resp_data, 64'hEEEE);
    idle();

    // reset mid-flight: later response to the old tag is dropped
    dc_req_valid = 1; dc_req_addr = 32'hB00; mem_accept_tag = 4'd8;
    tick();
    idle();
    reset = 1;
    tick();
    reset = 0;
    check("post_rst_dc_addr", 64'(dc_resp_addr), 64'd0);
    mem_resp_tag = 4'd8; mem_resp_data = 64'h8888;
    tick();
    check("post_rst_dc_valid", 64'(dc_resp_valid), 64'd0);
    check("post_rst_ic_valid", 64'(ic_resp_valid), 64'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
